// File: rtl/a51_keystream_gen_pkg.sv
// A5/1 keystream generator shared definitions.
// State encoding, register geometry, tap and clock-bit positions.
package a51_keystream_gen_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_FRAME = 3'd2;
    localparam logic [2:0] ST_MIX   = 3'd3;
    localparam logic [2:0] ST_GEN   = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

    localparam int KEY_CYCLES     = 64;
    localparam int FRAME_CYCLES   = 22;
    localparam int KS_BYTES_DEF   = 28;
    localparam int MIX_CYCLES_DEF = 100;

    localparam int R1_LEN = 19;
    localparam int R2_LEN = 22;
    localparam int R3_LEN = 23;

    localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
    localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
    localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    function automatic logic maj3(input logic a, input logic b,
                                  input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_keystream_gen_if.sv
// Control and keystream handshake bundle of the A5/1 generator.
// master: processor side; slave: generator side.
interface a51_keystream_gen_if;

    logic        start;
    logic [63:0] key_in;
    logic [21:0] frame_in;
    logic [7:0]  ks_byte;
    logic        ks_valid;
    logic        ks_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, key_in, frame_in, ks_ready,
        input  ks_byte, ks_valid, busy, done
    );

    modport slave (
        input  start, key_in, frame_in, ks_ready,
        output ks_byte, ks_valid, busy, done
    );

endinterface

// File: rtl/a51_lfsr.sv
// One A5/1 shift register: R <= {R[LEN-2:0], fb}, fb = taps ^ inject.
// Ports: en steps, clear zeroes; msb, clock bit and next msb out.
module a51_lfsr #(
    parameter int             LEN     = 19,
    parameter logic [LEN-1:0] TAPS    = '0,
    parameter int             CLK_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic inject,
    input  logic clear,
    output logic msb,
    output logic clk_bit,
    output logic next_msb
);

    logic [LEN-1:0] r;
    logic           fb;

    assign fb = (^(r & TAPS)) ^ inject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (clear) begin
            r <= '0;
        end else if (en) begin
            r <= {r[LEN-2:0], fb};
        end
    end

    assign msb      = r[LEN-1];
    assign clk_bit  = r[CLK_BIT];
    // msb after a step, so the output bit can use post-step values
    assign next_msb = r[LEN-2];

endmodule

// File: rtl/a51_keystream_gen.sv
// A5/1 keystream generator: key/frame load, warm-up, byte output.
// Ports: inclock, resetn, bus (start/key/frame in, ks_byte handshake out).
module a51_keystream_gen
    import a51_keystream_gen_pkg::*;
#(
    parameter int KS_BYTES   = KS_BYTES_DEF,
    parameter int MIX_CYCLES = MIX_CYCLES_DEF
) (
    input logic                inclock,
    input logic                resetn,
    a51_keystream_gen_if.slave bus
);

    logic [2:0]  state;
    logic [6:0]  step_cnt;
    logic [4:0]  byte_cnt;
    logic [63:0] key_q;
    logic [21:0] frame_q;
    logic [7:0]  ks_byte_q;
    logic        ks_valid_q;
    logic        busy_q;
    logic        done_q;

    logic c1, c2, c3;
    logic m1, m2, m3;
    logic n1, n2, n3;
    logic en1, en2, en3;
    logic bulk_step, maj_step, maj;
    logic clr, inject, ks_bit;

    assign bulk_step = (state == ST_KEY) || (state == ST_FRAME);
    assign maj_step  = (state == ST_MIX) || (state == ST_GEN);
    assign maj       = maj3(c1, c2, c3);

    assign en1 = bulk_step | (maj_step & (c1 == maj));
    assign en2 = bulk_step | (maj_step & (c2 == maj));
    assign en3 = bulk_step | (maj_step & (c3 == maj));

    // done marks the IDLE entry cycle, where start must be ignored
    assign clr = (state == ST_IDLE) & bus.start & ~done_q;

    always_comb begin
        inject = 1'b0;
        unique case (1'b1)
            state == ST_KEY:   inject = key_q[step_cnt[5:0]];
            state == ST_FRAME: inject = frame_q[step_cnt[4:0]];
            default:           inject = 1'b0;
        endcase
    end

    assign ks_bit = (en1 ? n1 : m1) ^ (en2 ? n2 : m2) ^ (en3 ? n3 : m3);

    a51_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
        .clk(inclock), .rst_n(resetn), .en(en1), .inject(inject),
        .clear(clr), .msb(m1), .clk_bit(c1), .next_msb(n1)
    );

    a51_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
        .clk(inclock), .rst_n(resetn), .en(en2), .inject(inject),
        .clear(clr), .msb(m2), .clk_bit(c2), .next_msb(n2)
    );

    a51_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
        .clk(inclock), .rst_n(resetn), .en(en3), .inject(inject),
        .clear(clr), .msb(m3), .clk_bit(c3), .next_msb(n3)
    );

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            step_cnt   <= '0;
            byte_cnt   <= '0;
            key_q      <= '0;
            frame_q    <= '0;
            ks_byte_q  <= '0;
            ks_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (clr) begin
                        key_q    <= bus.key_in;
                        frame_q  <= bus.frame_in;
                        step_cnt <= '0;
                        byte_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    if (step_cnt == 7'(KEY_CYCLES - 1)) begin
                        step_cnt <= '0;
                        state    <= ST_FRAME;
                    end else begin
                        step_cnt <= step_cnt + 7'd1;
                    end
                end
                ST_FRAME: begin
                    if (step_cnt == 7'(FRAME_CYCLES - 1)) begin
                        step_cnt <= '0;
                        state    <= ST_MIX;
                    end else begin
                        step_cnt <= step_cnt + 7'd1;
                    end
                end
                ST_MIX: begin
                    if (step_cnt == 7'(MIX_CYCLES - 1)) begin
                        step_cnt <= '0;
                        state    <= ST_GEN;
                    end else begin
                        step_cnt <= step_cnt + 7'd1;
                    end
                end
                ST_GEN: begin
                    ks_byte_q <= {ks_byte_q[6:0], ks_bit};
                    if (step_cnt == 7'd7) begin
                        step_cnt   <= '0;
                        ks_valid_q <= 1'b1;
                        state      <= ST_HOLD;
                    end else begin
                        step_cnt <= step_cnt + 7'd1;
                    end
                end
                ST_HOLD: begin
                    if (bus.ks_ready) begin
                        ks_valid_q <= 1'b0;
                        if (byte_cnt == 5'(KS_BYTES - 1)) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                            state    <= ST_GEN;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ks_byte  = ks_byte_q;
    assign bus.ks_valid = ks_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
